serial_addsub: RTL and testbench

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/addsub_pkg.sv | 13 +
 rtl/digit_adder.sv | 25 ++
 rtl/serial_addsub.sv | 115 +++++++++++
 tb/tb_serial_addsub.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and defaults for the digit-serial adder/subtractor.
package addsub_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_adder.sv
// DIGIT-bit ripple-carry adder; also exposes the carry into the top bit for overflow detection.
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             c_msb,
  output logic             cout
);

  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign c_msb = c[DIGIT-1];
  assign cout  = c[DIGIT];

endmodule

// File: rtl/serial_addsub.sv
// Digit-serial two's complement add/subtract with optional signed saturation.
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | one digit per cycle, LSB digit first
// DONE  | result held, out_valid=1 until out_ready
module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             addsub,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ov_flag
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic             sub_q, sat_q;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             last;

  logic [DIGIT-1:0] a_dig, b_dig, sum_dig;
  logic             c_msb, c_out;

  assign last  = (cnt == CW'(NDIG - 1));
  assign a_dig = a_q[int'(cnt)*DIGIT +: DIGIT];
  assign b_dig = b_q[int'(cnt)*DIGIT +: DIGIT] ^ {DIGIT{sub_q}};

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_dig),
    .b     (b_dig),
    .cin   (carry),
    .sum   (sum_dig),
    .c_msb (c_msb),
    .cout  (c_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = CALC;
      CALC:    if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sat_q   <= 1'b0;
      cnt     <= '0;
      carry   <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      ov_flag <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= A;
            b_q   <= B;
            sub_q <= addsub;
            sat_q <= sat_en;
            cnt   <= '0;
            carry <= addsub;
          end
        end
        CALC: begin
          carry <= c_out;
          cnt   <= cnt + CW'(1);
          if (last) begin
            Cout    <= c_out;
            ov_flag <= c_msb ^ c_out;
            // Only the last digit can overflow, so saturation overrides the whole word here.
            if (sat_q && (c_msb ^ c_out)) S <= a_q[WIDTH-1] ? MIN_NEG : MAX_POS;
            else                          S[int'(cnt)*DIGIT +: DIGIT] <= sum_dig;
          end else begin
            S[int'(cnt)*DIGIT +: DIGIT] <= sum_dig;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: directed corner cases plus randomized operations vs. an arithmetic model.
module tb_serial_addsub;

  localparam int WIDTH = 16;
  localparam int DIGIT = 4;
  localparam int NDIG  = WIDTH / DIGIT;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A, B;
  logic             addsub, sat_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout, ov_flag;

  int n_cmp = 0;
  int n_err = 0;

  serial_addsub #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .addsub    (addsub),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .Cout      (Cout),
    .ov_flag   (ov_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on signed values, saturation clamps to the representable range.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic sub, input logic sat,
                                output logic [15:0] s, output logic c, output logic ov);
    logic [16:0] full;
    int sa, sb, r;
    full = sub ? ({1'b0, a} + {1'b0, ~b} + 17'd1) : ({1'b0, a} + {1'b0, b});
    sa = int'($signed(a));
    sb = int'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    ov = (r > 32767) || (r < -32768);
    c  = full[16];
    s  = (sat && ov) ? ((r > 0) ? 16'h7FFF : 16'h8000) : full[15:0];
  endfunction

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic sub, input logic sat, input int stall, input bit disturb);
    logic [15:0] es;
    logic        ec, eov;
    int          k;
    model(a, b, sub, sat, es, ec, eov);
    @(negedge clk);
    chk({tag, "/idle_rdy"}, 32'(in_ready), 32'd1);
    A = a; B = b; addsub = sub; sat_en = sat; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "/calc_rdy"}, 32'(in_ready), 32'd0);
    k = 0;
    while (!out_valid && k < 20) begin
      if (disturb) begin
        in_valid = 1'($urandom_range(0, 1));
        A = 16'($urandom); B = 16'($urandom);
        addsub = 1'($urandom_range(0, 1)); sat_en = 1'($urandom_range(0, 1));
      end
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    out_ready = 1'b0;
    chk({tag, "/latency"}, 32'(k), 32'(NDIG));
    chk({tag, "/S"}, 32'(S), 32'(es));
    chk({tag, "/Cout"}, 32'(Cout), 32'(ec));
    chk({tag, "/ov"}, 32'(ov_flag), 32'(eov));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      A = 16'($urandom); B = 16'($urandom);
      @(posedge clk); #1;
      chk({tag, "/stall_S"}, 32'(S), 32'(es));
      chk({tag, "/stall_vld"}, {30'd0, out_valid, in_ready}, 32'd2);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    chk({tag, "/release"}, {30'd0, out_valid, in_ready}, 32'd1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int k;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; addsub = 1'b0; sat_en = 1'b0;
    #12;
    chk("reset_out", {13'd0, out_valid, in_ready, Cout, ov_flag, S}, {13'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
    @(negedge clk); rst = 1'b0;

    run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 0, 1'b0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 1, 1'b0);
    run_op("sub_neg",   16'h0005, 16'h0007, 1'b1, 1'b0, 0, 1'b0);
    run_op("add_ov",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op("add_sat",   16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
    run_op("sub_ov",    16'h8000, 16'h0001, 1'b1, 1'b0, 0, 1'b0);
    run_op("sub_sat",   16'h8000, 16'h0001, 1'b1, 1'b1, 0, 1'b0);
    run_op("stall",     16'h4321, 16'hABCD, 1'b0, 1'b0, 3, 1'b1);

    // Reset in the second CALC cycle aborts the operation.
    @(negedge clk);
    A = 16'h7FFF; B = 16'h7FFF; addsub = 1'b0; sat_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1; #1;
    chk("abort_out", {13'd0, out_valid, in_ready, Cout, ov_flag, S}, {13'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0});
    @(negedge clk); rst = 1'b0;
    k = 0;
    for (int i = 0; i < NDIG + 2; i++) begin
      @(posedge clk); #1;
      if (out_valid) k++;
    end
    chk("abort_no_vld", 32'(k), 32'd0);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 5 == 0) ra = {ra[15], {15{~ra[15]}}};
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
